// File: rtl/control_unit.sv
// Instruction-sequencing controller: owns PC, IR and the main FSM, fetches
// 16-bit instructions from a synchronous ROM and drives datapath controls.
module control_unit #(
  parameter int PC_W = 7
) (
  input  logic            Clock,
  input  logic            Reset,
  output logic [PC_W-1:0] Instr_Addr,
  input  logic [15:0]     Instr_Data,
  output logic [7:0]      D_Addr,
  output logic            D_W_en,
  output logic            RF_s,
  output logic [3:0]      RF_W_Addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_Addr,
  output logic [3:0]      RF_Rb_Addr,
  output logic [2:0]      ALU_s0,
  output logic [15:0]     IR_Out,
  output logic [3:0]      State
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_STORE = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'h5;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_INIT: begin
        state_d = S_FETCH;
        pc_d    = '0;
        ir_d    = '0;
      end
      S_FETCH: begin
        state_d = S_DECODE;
        ir_d    = Instr_Data;
        pc_d    = pc_q + PC_W'(1);
      end
      S_DECODE: begin
        case (ir_q[15:12])
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B, S_STORE, S_ADD, S_SUB, S_NOOP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Moore outputs: a function of the current state and IR only, so an
  // asynchronous Reset zeroes every write enable within the same cycle.
  always_comb begin
    D_Addr     = '0;
    D_W_en     = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    ALU_s0     = 3'd0;
    case (state_q)
      S_LOAD_A, S_LOAD_B: begin
        D_Addr    = ir_q[11:4];
        RF_s      = 1'b1;
        RF_W_Addr = ir_q[3:0];
        RF_W_en   = (state_q == S_LOAD_B);
      end
      S_STORE: begin
        D_Addr     = ir_q[11:4];
        RF_Ra_Addr = ir_q[3:0];
        D_W_en     = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_Addr = ir_q[11:8];
        RF_Rb_Addr = ir_q[7:4];
        RF_W_Addr  = ir_q[3:0];
        RF_W_en    = 1'b1;
        ALU_s0     = (state_q == S_ADD) ? 3'd1 : 3'd2;
      end
      default: ;
    endcase
  end

  assign Instr_Addr = pc_q;
  assign IR_Out     = ir_q;
  assign State      = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: synchronous ROM, RAM, register file and ALU around
// the DUT, checked cycle by cycle against an instruction-level model.
module tb_control_unit;

  localparam int PC_W = 7;

  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic [PC_W-1:0] Instr_Addr;
  logic [15:0]     Instr_Data;
  logic [7:0]      D_Addr;
  logic            D_W_en;
  logic            RF_s;
  logic [3:0]      RF_W_Addr;
  logic            RF_W_en;
  logic [3:0]      RF_Ra_Addr;
  logic [3:0]      RF_Rb_Addr;
  logic [2:0]      ALU_s0;
  logic [15:0]     IR_Out;
  logic [3:0]      State;

  control_unit #(.PC_W(PC_W)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Instr_Addr (Instr_Addr),
    .Instr_Data (Instr_Data),
    .D_Addr     (D_Addr),
    .D_W_en     (D_W_en),
    .RF_s       (RF_s),
    .RF_W_Addr  (RF_W_Addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_Addr (RF_Ra_Addr),
    .RF_Rb_Addr (RF_Rb_Addr),
    .ALU_s0     (ALU_s0),
    .IR_Out     (IR_Out),
    .State      (State)
  );

  always #5 Clock = ~Clock;

  // Attached memories and datapath
  logic [15:0] rom      [128];
  logic [15:0] ram_init [256];
  logic [15:0] rf_init  [16];
  logic [15:0] dp_ram   [256];
  logic [15:0] dp_rf    [16];
  logic [15:0] dp_rd;
  logic [15:0] dp_alu;
  logic        dp_load = 1'b1;

  always @(posedge Clock) Instr_Data <= rom[Instr_Addr];

  always_comb begin
    dp_alu = dp_rf[RF_Ra_Addr];
    if (ALU_s0 == 3'd1) dp_alu = dp_rf[RF_Ra_Addr] + dp_rf[RF_Rb_Addr];
    else if (ALU_s0 == 3'd2) dp_alu = dp_rf[RF_Ra_Addr] - dp_rf[RF_Rb_Addr];
  end

  always @(posedge Clock) begin
    if (dp_load) begin
      for (int i = 0; i < 256; i++) dp_ram[i] <= ram_init[i];
      for (int i = 0; i < 16; i++) dp_rf[i] <= rf_init[i];
      dp_rd <= '0;
    end else begin
      dp_rd <= dp_ram[D_Addr];
      if (D_W_en) dp_ram[D_Addr] <= dp_rf[RF_Ra_Addr];
      if (RF_W_en) dp_rf[RF_W_Addr] <= RF_s ? dp_rd : dp_alu;
    end
  end

  // Instruction-level reference model
  typedef struct packed {
    logic [52:0] outs;
    logic [1:0]  kind;   // 0 none, 1 store, 2 load, 3 alu
    logic [15:0] w;
  } exp_t;

  exp_t        q[$];
  exp_t        pend;
  bit          pend_v;
  logic [6:0]  m_pc;
  logic [15:0] m_ir;
  bit          m_halt;
  logic [15:0] m_ram [256];
  logic [15:0] m_rf  [16];
  int          checks = 0;
  int          errors = 0;
  int          dwen_cnt;
  int          fetch_cnt;
  int          rst_left;

  function automatic logic [52:0] pk(logic [3:0] st, logic [6:0] pc, logic [15:0] ir,
                                     logic [7:0] da, logic dwe, logic rfs, logic [3:0] wa,
                                     logic we, logic [3:0] ra, logic [3:0] rb, logic [2:0] alu);
    return {st, pc, ir, da, dwe, rfs, wa, we, ra, rb, alu};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic push(input logic [52:0] o, input logic [1:0] k, input logic [15:0] w);
    exp_t e;
    e.outs = o;
    e.kind = k;
    e.w    = w;
    q.push_back(e);
  endtask

  // Expand one instruction into the cycles it must produce.
  task automatic gen_instr();
    logic [15:0] w;
    w = rom[m_pc];
    push(pk(4'd1, m_pc, m_ir, 8'd0, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0), 2'd0, w);
    m_pc = m_pc + 7'd1;
    m_ir = w;
    push(pk(4'd2, m_pc, w, 8'd0, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0), 2'd0, w);
    case (w[15:12])
      4'h1: push(pk(4'd6, m_pc, w, w[11:4], 1, 0, 4'd0, 0, w[3:0], 4'd0, 3'd0), 2'd1, w);
      4'h2: begin
        push(pk(4'd4, m_pc, w, w[11:4], 0, 1, w[3:0], 0, 4'd0, 4'd0, 3'd0), 2'd0, w);
        push(pk(4'd5, m_pc, w, w[11:4], 0, 1, w[3:0], 1, 4'd0, 4'd0, 3'd0), 2'd2, w);
      end
      4'h3: push(pk(4'd7, m_pc, w, 8'd0, 0, 0, w[3:0], 1, w[11:8], w[7:4], 3'd1), 2'd3, w);
      4'h4: push(pk(4'd8, m_pc, w, 8'd0, 0, 0, w[3:0], 1, w[11:8], w[7:4], 3'd2), 2'd3, w);
      4'h5: m_halt = 1;
      default: push(pk(4'd3, m_pc, w, 8'd0, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0), 2'd0, w);
    endcase
  endtask

  task automatic apply_effect(input exp_t e);
    case (e.kind)
      2'd1: m_ram[e.w[11:4]] = m_rf[e.w[3:0]];
      2'd2: m_rf[e.w[3:0]] = m_ram[e.w[11:4]];
      2'd3: m_rf[e.w[3:0]] = (e.w[15:12] == 4'h3) ? m_rf[e.w[11:8]] + m_rf[e.w[7:4]]
                                                  : m_rf[e.w[11:8]] - m_rf[e.w[7:4]];
      default: ;
    endcase
  endtask

  // One clock: advance to the falling edge and compare every output.
  task automatic tick();
    exp_t        e;
    logic [52:0] act;
    @(negedge Clock);
    act = pk(State, Instr_Addr, IR_Out, D_Addr, D_W_en, RF_s, RF_W_Addr, RF_W_en,
             RF_Ra_Addr, RF_Rb_Addr, ALU_s0);
    if (Reset) begin
      q.delete();
      m_pc = '0;
      m_ir = '0;
      m_halt = 0;
      pend_v = 0;
      check("reset_outputs", act, pk(4'd0, 7'd0, 16'd0, 8'd0, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0));
    end else begin
      if (pend_v) apply_effect(pend);
      pend_v = 0;
      if (q.size() == 0) begin
        if (m_halt) push(pk(4'd9, m_pc, m_ir, 8'd0, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'd0), 2'd0, 16'd0);
        else gen_instr();
      end
      e = q.pop_front();
      check("cycle_outputs", act, e.outs);
      if (e.kind != 2'd0) begin
        pend   = e;
        pend_v = 1;
      end
    end
    if (D_W_en) dwen_cnt++;
    if (State == 4'd1) fetch_cnt++;
  endtask

  task automatic reset_begin();
    tick();
    #1;
    Reset   = 1'b1;
    dp_load = 1'b1;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 256; i++) ram_init[i] = 16'h0000;
    for (int i = 0; i < 16; i++) rf_init[i] = 16'h0000;
  endtask

  task automatic reset_end();
    for (int i = 0; i < 256; i++) m_ram[i] = ram_init[i];
    for (int i = 0; i < 16; i++) m_rf[i] = rf_init[i];
    tick();
    tick();
    #1;
    dp_load   = 1'b0;
    Reset     = 1'b0;
    dwen_cnt  = 0;
    fetch_cnt = 0;
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string name);
    int n = 0;
    while (State !== s && n < budget) begin
      tick();
      n++;
    end
    check(name, State, s);
  endtask

  task automatic compare_memories();
    for (int i = 0; i < 16; i++) check("rf_contents", dp_rf[i], m_rf[i]);
    for (int i = 0; i < 256; i++) check("ram_contents", dp_ram[i], m_ram[i]);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;

    // LOAD then verify
    reset_begin();
    rom[0] = 16'h2000; rom[1] = 16'h5000; ram_init[0] = 16'd20;
    reset_end();
    tick(); check("load_fetch", State, 4'd1);
    tick(); check("load_decode", State, 4'd2);
    tick(); check("load_a_state", State, 4'd4);
    check("load_a_ctl", {D_Addr, RF_s, RF_W_en}, {8'd0, 1'b1, 1'b0});
    tick(); check("load_b_state", State, 4'd5);
    check("load_b_ctl", {D_Addr, RF_s, RF_W_en}, {8'd0, 1'b1, 1'b1});
    tick(); check("load_next_fetch", State, 4'd1);
    wait_state(4'd9, 20, "load_halt");
    check("load_r0", dp_rf[0], 16'd20);

    // ADD program
    reset_begin();
    rom[0] = 16'h2000; rom[1] = 16'h2011; rom[2] = 16'h3012; rom[3] = 16'h5000;
    ram_init[0] = 16'd20; ram_init[1] = 16'd25;
    reset_end();
    wait_state(4'd7, 40, "add_reach");
    check("add_ctl", {ALU_s0, RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr}, {3'd1, 4'd0, 4'd1, 4'd2});
    wait_state(4'd9, 20, "add_halt");
    repeat (20) tick();
    check("add_halt_hold", {State, Instr_Addr}, {4'd9, 7'd4});
    check("add_r2", dp_rf[2], 16'd45);

    // SUB and STORE
    reset_begin();
    rom[0] = 16'h2000; rom[1] = 16'h2011; rom[2] = 16'h4103; rom[3] = 16'h1023; rom[4] = 16'h5000;
    ram_init[0] = 16'd20; ram_init[1] = 16'd25;
    reset_end();
    wait_state(4'd6, 60, "store_reach");
    check("store_ctl", {D_W_en, D_Addr, RF_Ra_Addr}, {1'b1, 8'd2, 4'd3});
    wait_state(4'd9, 20, "sub_halt");
    repeat (5) tick();
    check("store_wen_cycles", dwen_cnt, 1);
    check("sub_r3", dp_rf[3], 16'd5);
    check("store_ram2", dp_ram[2], 16'd5);

    // Undefined opcode runs as NOOP
    reset_begin();
    rom[0] = 16'hF123; rom[1] = 16'h5000;
    reset_end();
    tick(); check("undef_fetch", State, 4'd1);
    tick(); check("undef_decode", State, 4'd2);
    tick(); check("undef_noop", {State, Instr_Addr, D_W_en, RF_W_en}, {4'd3, 7'd1, 1'b0, 1'b0});

    // Reset in the middle of LOAD_B
    reset_begin();
    rom[0] = 16'h2000; ram_init[0] = 16'h00AA; rf_init[0] = 16'h1234;
    reset_end();
    wait_state(4'd5, 10, "rst_reach_load_b");
    #1 Reset = 1'b1;
    #1 check("rst_immediate", {State, Instr_Addr, IR_Out, RF_W_en}, {4'd0, 7'd0, 16'd0, 1'b0});
    tick();
    check("rst_rf_untouched", dp_rf[0], 16'h1234);
    #1 Reset = 1'b0;
    tick(); check("rst_then_fetch", State, 4'd1);

    // PC wrap with a ROM full of NOOPs
    reset_begin();
    reset_end();
    for (int k = 1; k <= 385; k++) begin
      tick();
      if (k == 4) check("wrap_second_fetch", {State, Instr_Addr}, {4'd1, 7'd1});
    end
    check("wrap_pc_zero", {State, Instr_Addr}, {4'd1, 7'd0});
    check("wrap_fetch_count", fetch_cnt, 129);

    // Randomized programs with random mid-run resets
    for (int p = 0; p < 6; p++) begin
      reset_begin();
      for (int i = 0; i < 128; i++) begin
        logic [3:0] op;
        if ($urandom_range(0, 99) < 4) op = 4'h5;
        else begin
          op = 4'($urandom_range(0, 5));
          if (op == 4'h5) op = 4'($urandom_range(6, 15));
        end
        rom[i] = {op, 12'($urandom)};
      end
      for (int i = 0; i < 256; i++) ram_init[i] = 16'($urandom);
      for (int i = 0; i < 16; i++) rf_init[i] = 16'($urandom);
      reset_end();
      for (int c = 0; c < 400; c++) begin
        tick();
        if (!Reset && $urandom_range(0, 59) == 0) begin
          #1 Reset = 1'b1;
          rst_left = $urandom_range(1, 3);
        end else if (Reset) begin
          rst_left--;
          if (rst_left == 0) #1 Reset = 1'b0;
        end
      end
      if (Reset) begin
        #1 Reset = 1'b0;
      end
      tick();
      compare_memories();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
